// File: rtl/parity_frame_receiver.sv
// rtl/parity_frame_receiver.sv - strobed serial receiver for start/4-data/parity/stop frames
module parity_frame_receiver (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       bit_en,
    input  logic       odd_mode,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     state;
    logic [1:0] bit_cnt;
    logic [3:0] shift_data;
    logic       par_bit;
    logic       mode_q;

    // Frame FSM: advances one bit per strobe, publishes results on the stop-bit strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= 2'd0;
            shift_data <= 4'd0;
            par_bit    <= 1'b0;
            mode_q     <= 1'b0;
            data_out   <= 4'd0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // data_valid is a single-cycle pulse regardless of strobe spacing
            data_valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    S_IDLE: begin
                        if (!rx_in) begin
                            state   <= S_DATA;
                            bit_cnt <= 2'd0;
                            mode_q  <= odd_mode;
                            busy    <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        shift_data[bit_cnt] <= rx_in;
                        bit_cnt             <= bit_cnt + 2'd1;
                        if (bit_cnt == 2'd3) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_bit <= rx_in;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        data_out   <= shift_data;
                        // Odd mode inverts the even-parity check result
                        parity_err <= (^shift_data) ^ par_bit ^ mode_q;
                        frame_err  <= ~rx_in;
                        data_valid <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/parity_frame_receiver.md
PARITY_FRAME_RECEIVER -- requirements
Module: parity_frame_receiver

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk, rst.
REQ-002 The block SHALL expose `clk  input  1  rising-edge clock for all state`.
REQ-003 The block SHALL expose `rst  input  1  synchronous active-high reset`.
REQ-004 The block SHALL expose `rx_in  input  1  serial line, idle high`.
REQ-005 The block SHALL expose `bit_en  input  1  sample strobe; rx_in is sampled only on edges where bit_en=1`.
REQ-006 The block SHALL expose `odd_mode  input  1  0 = even parity expected, 1 = odd parity expected`.
REQ-007 The block SHALL expose `data_out  output  4  last received data nibble`.
REQ-008 The block SHALL expose `data_valid  output  1  one-cycle pulse when a frame completes`.
REQ-009 The block SHALL expose `parity_err  output  1  parity result for the last frame`.
REQ-010 The block SHALL expose `frame_err  output  1  stop-bit result for the last frame`.
REQ-011 The block SHALL expose `busy  output  1  high while a frame is in progress`.

Function
REQ-012 The frame SHALL be: start bit (0), d0..d3 LSB first, one parity bit, one stop bit (1), with one bit per bit_en edge.
REQ-013 The FSM SHALL have four states:
- IDLE
- DATA, with a 2-bit counter running 0..3
- PARITY
- STOP
REQ-014 In IDLE, an edge with bit_en=1 and rx_in=0 SHALL move to DATA with the counter at 0; rx_in=1 SHALL stay in IDLE.
REQ-015 odd_mode SHALL be latched on the start-bit edge and used for the whole frame; later changes SHALL be ignored until the next frame.
REQ-016 In DATA, each bit_en edge SHALL store rx_in into bit[counter]; after counter=3 the FSM SHALL move to PARITY.
REQ-017 In PARITY, the bit_en edge SHALL store the parity bit p and move to STOP.
REQ-018 Parity error SHALL be computed as:
- even mode: err = XOR(d3..d0, p)
- odd mode: err = NOT XOR(d3..d0, p)
REQ-019 In STOP, on the bit_en edge the block SHALL, on that same edge:
- load data_out with the received nibble
- set parity_err per REQ-018
- set frame_err = NOT rx_in
- assert data_valid
- return to IDLE
REQ-020 data_valid SHALL be high for exactly one clock; latency is 0 cycles after the stop-sampling edge, i.e. visible in the following cycle.
REQ-021 A frame with a stop error SHALL still deliver data and pulse data_valid; there SHALL be no break detection or resync beyond returning to IDLE.
REQ-022 A new start bit SHALL be accepted on the first bit_en edge after STOP completes, so back-to-back frames have no gap.
REQ-023 Edges with bit_en=0 SHALL hold all state; rx_in activity on those edges SHALL be ignored.
REQ-024 data_out, parity_err and frame_err SHALL hold their values until the next frame completes; they are meaningful only when qualified by data_valid.
REQ-025 busy SHALL be 1 in DATA, PARITY and STOP, and 0 in IDLE, decoded from registered state.

Reset
REQ-026 While rst=1 at a clk edge, the block SHALL clear the state to IDLE and zero the counter, data_out, data_valid, parity_err, frame_err, busy and the latched mode.
REQ-027 Reset SHALL take priority over bit_en.
REQ-028 A reset mid-frame SHALL discard the partial frame with no data_valid pulse.
REQ-029 The first clk edge with rst=0 SHALL be a normal IDLE edge.

Verification
REQ-030 Even-mode frame, odd_mode=0, bit_en=1 every cycle, bits start 0, 1,0,1,0 (data 4'b0101), parity 0, stop 1 -> data_out=0101, parity_err=0, frame_err=0, data_valid high exactly one cycle, busy 1 for 6 cycles.
REQ-031 Odd mode, odd_mode=1, data 4'b0111, parity 0 -> parity_err=0; the same frame with parity 1 -> parity_err=1 and data_out=0111.
REQ-032 Even mode, data 4'b1100, parity 0, stop bit 0 -> frame_err=1, parity_err=0, data_valid pulses; an immediately following frame with data 4'b0011 SHALL be received correctly.
REQ-033 Strobe gaps: frame as in REQ-030 with bit_en high only every 3rd cycle and rx_in toggled on non-strobe cycles -> result identical to REQ-030; data_valid appears one cycle after the 7th strobe edge.
REQ-034 Reset mid-frame: rst pulsed for one cycle after two data bits -> busy=0, data_valid never pulses, outputs 0; a subsequent frame with data 4'b1010, even mode, parity 0 -> data_out=1010, no errors.
REQ-035 Idle line: rx_in=1, bit_en=1 for 20 cycles -> busy=0 and data_valid=0 throughout; flipping odd_mode during idle has no effect.
